// File: rtl/arc_cu_pkg.sv
// Shared types and constants for the ARC control unit: state encoding,
// special register addresses, ALU operation codes and opcode fields.
package arc_cu_pkg;

    typedef enum logic [4:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_ALU,
        S_SETHI,
        S_LDA,
        S_STA,
        S_LDW,
        S_STW,
        S_BR,
        S_BR2,
        S_CALL1,
        S_CALL2,
        S_CALL3,
        S_JMP1,
        S_JMP2,
        S_JMP3,
        S_PCINC,
        S_HALT
    } state_t;

    localparam logic [5:0] REG_R0    = 6'd0;
    localparam logic [5:0] REG_R15   = 6'd15;
    localparam logic [5:0] REG_PC    = 6'd32;
    localparam logic [5:0] REG_TEMP0 = 6'd33;
    localparam logic [5:0] REG_IR    = 6'd37;

    localparam logic [3:0] ALU_ANDCC    = 4'h0;
    localparam logic [3:0] ALU_ORCC     = 4'h1;
    localparam logic [3:0] ALU_ORNCC    = 4'h2;
    localparam logic [3:0] ALU_ADDCC    = 4'h3;
    localparam logic [3:0] ALU_SRL      = 4'h4;
    localparam logic [3:0] ALU_AND      = 4'h5;
    localparam logic [3:0] ALU_OR       = 4'h6;
    localparam logic [3:0] ALU_ORN      = 4'h7;
    localparam logic [3:0] ALU_ADD      = 4'h8;
    localparam logic [3:0] ALU_LSHIFT2  = 4'h9;
    localparam logic [3:0] ALU_LSHIFT10 = 4'hA;
    localparam logic [3:0] ALU_DISP30   = 4'hB;
    localparam logic [3:0] ALU_DISP22   = 4'hC;
    localparam logic [3:0] ALU_INC      = 4'hD;
    localparam logic [3:0] ALU_INCPC    = 4'hE;
    localparam logic [3:0] ALU_RSHIFT5  = 4'hF;

    localparam logic [1:0] OP_FMT2  = 2'b00;
    localparam logic [1:0] OP_CALL  = 2'b01;
    localparam logic [1:0] OP_ARITH = 2'b10;
    localparam logic [1:0] OP_MEM   = 2'b11;

    localparam logic [2:0] OP2_SETHI = 3'b100;
    localparam logic [2:0] OP2_BR    = 3'b010;

    localparam logic [5:0] OP3_ADDCC = 6'b010000;
    localparam logic [5:0] OP3_ANDCC = 6'b010001;
    localparam logic [5:0] OP3_ORCC  = 6'b010010;
    localparam logic [5:0] OP3_ORNCC = 6'b010110;
    localparam logic [5:0] OP3_SRL   = 6'b100110;
    localparam logic [5:0] OP3_JMPL  = 6'b111000;
    localparam logic [5:0] OP3_LD    = 6'b000000;
    localparam logic [5:0] OP3_ST    = 6'b000100;

endpackage

// File: rtl/arc_cu_decoder.sv
// Combinational instruction classifier: maps the decoded opcode to the first
// execute state of the instruction and, for arithmetic ops, the ALU code.
module arc_cu_decoder
    import arc_cu_pkg::*;
(
    input  logic [7:0] decodeOp_i,
    output state_t     nextState_o,
    output logic [3:0] aluOp_o
);

    logic [1:0] op;
    logic [2:0] op2;
    logic [5:0] op3;

    assign op  = decodeOp_i[7:6];
    assign op2 = decodeOp_i[5:3];
    assign op3 = decodeOp_i[5:0];

    // Unknown encodings fall through to HALT.
    always_comb begin
        nextState_o = S_HALT;
        aluOp_o     = ALU_AND;
        if (op != OP_FMT2 && op != OP_CALL && op3 == OP3_JMPL) begin
            nextState_o = S_JMP1;
        end else begin
            case (op)
                OP_FMT2: begin
                    if (op2 == OP2_SETHI)   nextState_o = S_SETHI;
                    else if (op2 == OP2_BR) nextState_o = S_BR;
                end
                OP_CALL: nextState_o = S_CALL1;
                OP_ARITH: begin
                    case (op3)
                        OP3_ADDCC: begin nextState_o = S_ALU; aluOp_o = ALU_ADDCC; end
                        OP3_ANDCC: begin nextState_o = S_ALU; aluOp_o = ALU_ANDCC; end
                        OP3_ORCC:  begin nextState_o = S_ALU; aluOp_o = ALU_ORCC;  end
                        OP3_ORNCC: begin nextState_o = S_ALU; aluOp_o = ALU_ORNCC; end
                        OP3_SRL:   begin nextState_o = S_ALU; aluOp_o = ALU_SRL;   end
                        default:   nextState_o = S_HALT;
                    endcase
                end
                default: begin
                    if (op3 == OP3_LD)      nextState_o = S_LDA;
                    else if (op3 == OP3_ST) nextState_o = S_STA;
                end
            endcase
        end
    end

endmodule

// File: rtl/arc_control_unit.sv
// Hardwired fetch/decode/execute sequencer for the 32-bit ARC datapath.
// Optional instruction counter enabled by defining ARC_CU_INSTRCOUNT_EN.
module arc_control_unit
    import arc_cu_pkg::*;
#(
    parameter int DATAWIDTH_DIRECTION     = 6,
    parameter int DATAWIDTH_DECODEROP     = 8,
    parameter int DATAWIDTH_ALU_SELECTION = 4
)
(
    input  logic                               CU_CLOCK_50,
    input  logic                               CU_ResetInHigh_In,
    input  logic [DATAWIDTH_DECODEROP-1:0]     CU_DecodeOP_InBus,
    input  logic                               CU_ConditionCode_In,
    input  logic                               CU_MemAck_In,
    output logic [DATAWIDTH_DIRECTION-1:0]     CU_DirA_OutBus,
    output logic [DATAWIDTH_DIRECTION-1:0]     CU_DirB_OutBus,
    output logic [DATAWIDTH_DIRECTION-1:0]     CU_DirC_OutBus,
    output logic                               CU_SelectA_Out,
    output logic                               CU_SelectB_Out,
    output logic                               CU_SelectC_Out,
    output logic                               CU_RdAsB_Out,
    output logic [DATAWIDTH_ALU_SELECTION-1:0] CU_ALUOperation_OutBus,
    output logic                               CU_RD_Out,
    output logic                               CU_MemRead_Out,
    output logic                               CU_MemWrite_Out,
    output logic                               CU_Halt_Out
`ifdef ARC_CU_INSTRCOUNT_EN
    ,
    output logic [31:0]                        CU_InstrCount_OutBus
`endif
);

    state_t     state_q, state_d;
    state_t     decNext;
    logic [3:0] decAlu;
    logic [3:0] aluOp_q;

    arc_cu_decoder u_decoder (
        .decodeOp_i  (CU_DecodeOP_InBus),
        .nextState_o (decNext),
        .aluOp_o     (decAlu)
    );

    // ALU code is captured in DECODE so the ALU state is purely state-driven.
    always_ff @(posedge CU_CLOCK_50) begin
        if (CU_ResetInHigh_In) begin
            state_q <= S_RESET;
            aluOp_q <= ALU_AND;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) aluOp_q <= decAlu;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  state_d = CU_MemAck_In ? S_DECODE : S_FETCH;
            S_DECODE: state_d = decNext;
            S_ALU:    state_d = S_PCINC;
            S_SETHI:  state_d = S_PCINC;
            S_LDA:    state_d = S_LDW;
            S_STA:    state_d = S_STW;
            S_LDW:    state_d = CU_MemAck_In ? S_PCINC : S_LDW;
            S_STW:    state_d = CU_MemAck_In ? S_PCINC : S_STW;
            S_BR:     state_d = CU_ConditionCode_In ? S_BR2 : S_PCINC;
            S_BR2:    state_d = S_FETCH;
            S_CALL1:  state_d = S_CALL2;
            S_CALL2:  state_d = S_CALL3;
            S_CALL3:  state_d = S_FETCH;
            S_JMP1:   state_d = S_JMP2;
            S_JMP2:   state_d = S_JMP3;
            S_JMP3:   state_d = S_FETCH;
            S_PCINC:  state_d = S_FETCH;
            default:  state_d = S_HALT;
        endcase
    end

    // In wait states the write target is only exposed on the ack cycle.
    always_comb begin
        CU_DirA_OutBus         = REG_R0;
        CU_DirB_OutBus         = REG_R0;
        CU_DirC_OutBus         = REG_R0;
        CU_SelectA_Out         = 1'b1;
        CU_SelectB_Out         = 1'b1;
        CU_SelectC_Out         = 1'b1;
        CU_RdAsB_Out           = 1'b0;
        CU_ALUOperation_OutBus = ALU_AND;
        CU_RD_Out              = 1'b0;
        CU_MemRead_Out         = 1'b0;
        CU_MemWrite_Out        = 1'b0;
        CU_Halt_Out            = 1'b0;
        case (state_q)
            S_FETCH: begin
                CU_DirA_OutBus = REG_PC;
                CU_MemRead_Out = 1'b1;
                CU_RD_Out      = 1'b1;
                CU_DirC_OutBus = CU_MemAck_In ? REG_IR : REG_R0;
            end
            S_ALU: begin
                CU_SelectA_Out         = 1'b0;
                CU_SelectB_Out         = 1'b0;
                CU_SelectC_Out         = 1'b0;
                CU_ALUOperation_OutBus = aluOp_q;
            end
            S_SETHI: begin
                CU_SelectC_Out         = 1'b0;
                CU_ALUOperation_OutBus = ALU_LSHIFT10;
            end
            S_LDA, S_STA, S_JMP1: begin
                CU_SelectA_Out         = 1'b0;
                CU_SelectB_Out         = 1'b0;
                CU_DirC_OutBus         = REG_TEMP0;
                CU_ALUOperation_OutBus = ALU_ADD;
            end
            S_LDW: begin
                CU_DirA_OutBus = REG_TEMP0;
                CU_MemRead_Out = 1'b1;
                CU_RD_Out      = 1'b1;
                CU_SelectC_Out = ~CU_MemAck_In;
            end
            S_STW: begin
                CU_DirA_OutBus  = REG_TEMP0;
                CU_RdAsB_Out    = 1'b1;
                CU_MemWrite_Out = 1'b1;
            end
            S_BR: begin
                CU_DirC_OutBus         = REG_TEMP0;
                CU_ALUOperation_OutBus = ALU_DISP22;
            end
            S_BR2, S_CALL3: begin
                CU_DirA_OutBus         = REG_PC;
                CU_DirB_OutBus         = REG_TEMP0;
                CU_DirC_OutBus         = REG_PC;
                CU_ALUOperation_OutBus = ALU_ADD;
            end
            S_CALL1: begin
                CU_DirA_OutBus         = REG_PC;
                CU_DirC_OutBus         = REG_R15;
                CU_ALUOperation_OutBus = ALU_OR;
            end
            S_CALL2: begin
                CU_DirC_OutBus         = REG_TEMP0;
                CU_ALUOperation_OutBus = ALU_DISP30;
            end
            S_JMP2: begin
                CU_DirA_OutBus         = REG_PC;
                CU_SelectC_Out         = 1'b0;
                CU_ALUOperation_OutBus = ALU_OR;
            end
            S_JMP3: begin
                CU_DirA_OutBus         = REG_TEMP0;
                CU_DirC_OutBus         = REG_PC;
                CU_ALUOperation_OutBus = ALU_OR;
            end
            S_PCINC: begin
                CU_DirA_OutBus         = REG_PC;
                CU_DirC_OutBus         = REG_PC;
                CU_ALUOperation_OutBus = ALU_INCPC;
            end
            S_HALT: CU_Halt_Out = 1'b1;
            default: ;
        endcase
    end

`ifdef ARC_CU_INSTRCOUNT_EN
    logic [31:0] instrCount_q, instrCount_d;

    // Counts retired instructions: every new fetch except the first after reset.
    always_comb begin
        instrCount_d = instrCount_q;
        if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_RESET)
            instrCount_d = instrCount_q + 32'd1;
    end

    always_ff @(posedge CU_CLOCK_50) begin
        if (CU_ResetInHigh_In) instrCount_q <= 32'd0;
        else                   instrCount_q <= instrCount_d;
    end

    assign CU_InstrCount_OutBus = instrCount_q;
`endif

endmodule

// File: tb/tb_arc_control_unit.sv
// Directed self-checking bench for arc_control_unit; exercises the
// instruction counter when ARC_CU_INSTRCOUNT_EN is defined.
module tb_arc_control_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] decodeOp;
    logic       condCode;
    logic       memAck;
    logic [5:0] dirA, dirB, dirC;
    logic       selA, selB, selC, rdAsB, rdOut, memRead, memWrite, halt;
    logic [3:0] aluOp;
`ifdef ARC_CU_INSTRCOUNT_EN
    logic [31:0] instrCount;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    arc_control_unit dut (
        .CU_CLOCK_50            (clock),
        .CU_ResetInHigh_In      (reset),
        .CU_DecodeOP_InBus      (decodeOp),
        .CU_ConditionCode_In    (condCode),
        .CU_MemAck_In           (memAck),
        .CU_DirA_OutBus         (dirA),
        .CU_DirB_OutBus         (dirB),
        .CU_DirC_OutBus         (dirC),
        .CU_SelectA_Out         (selA),
        .CU_SelectB_Out         (selB),
        .CU_SelectC_Out         (selC),
        .CU_RdAsB_Out           (rdAsB),
        .CU_ALUOperation_OutBus (aluOp),
        .CU_RD_Out              (rdOut),
        .CU_MemRead_Out         (memRead),
        .CU_MemWrite_Out        (memWrite),
        .CU_Halt_Out            (halt)
`ifdef ARC_CU_INSTRCOUNT_EN
        ,
        .CU_InstrCount_OutBus   (instrCount)
`endif
    );

    // Control vector layout: {dirA, dirB, dirC, selA/B/C, rdAsB, alu, rd, memRead, memWrite, halt}
    logic [29:0] obsCtl;
    assign obsCtl = {dirA, dirB, dirC, selA, selB, selC, rdAsB, aluOp, rdOut, memRead, memWrite, halt};

    function automatic logic [29:0] ctl(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                                        input logic [2:0] sel, input logic rab, input logic [3:0] alu,
                                        input logic rd, input logic mr, input logic mw, input logic hlt);
        return {a, b, c, sel, rab, alu, rd, mr, mw, hlt};
    endfunction

    task automatic applyStimulus(input logic rst, input logic ack, input logic [7:0] op, input logic cond);
        reset    = rst;
        memAck   = ack;
        decodeOp = op;
        condCode = cond;
    endtask

    task automatic stepClock();
        @(posedge clock);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    logic [29:0] vIdle, vFetchWait, vFetchAck, vAluAdd, vPcInc, vAddr, vLdwWait, vLdwAck;
    logic [29:0] vStw, vSethi, vBr, vBr2, vCall1, vCall2, vJmp2, vJmp3, vHalt;

    initial begin
        vIdle      = ctl(6'd0,  6'd0,  6'd0,  3'b111, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
        vFetchWait = ctl(6'd32, 6'd0,  6'd0,  3'b111, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0);
        vFetchAck  = ctl(6'd32, 6'd0,  6'd37, 3'b111, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0);
        vAluAdd    = ctl(6'd0,  6'd0,  6'd0,  3'b000, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        vPcInc     = ctl(6'd32, 6'd0,  6'd32, 3'b111, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
        vAddr      = ctl(6'd0,  6'd0,  6'd33, 3'b001, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0);
        vLdwWait   = ctl(6'd33, 6'd0,  6'd0,  3'b111, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0);
        vLdwAck    = ctl(6'd33, 6'd0,  6'd0,  3'b110, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0);
        vStw       = ctl(6'd33, 6'd0,  6'd0,  3'b111, 1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0);
        vSethi     = ctl(6'd0,  6'd0,  6'd0,  3'b110, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);
        vBr        = ctl(6'd0,  6'd0,  6'd33, 3'b111, 1'b0, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0);
        vBr2       = ctl(6'd32, 6'd33, 6'd32, 3'b111, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0);
        vCall1     = ctl(6'd32, 6'd0,  6'd15, 3'b111, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0);
        vCall2     = ctl(6'd0,  6'd0,  6'd33, 3'b111, 1'b0, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0);
        vJmp2      = ctl(6'd32, 6'd0,  6'd0,  3'b110, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0);
        vJmp3      = ctl(6'd33, 6'd0,  6'd32, 3'b111, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0);
        vHalt      = ctl(6'd0,  6'd0,  6'd0,  3'b111, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset and the RESET cycle that follows it
        applyStimulus(1'b1, 1'b1, 8'b10_010000, 1'b0);
        stepClock();
        stepClock();
        checkOutput("reset_held", obsCtl, vIdle);
`ifdef ARC_CU_INSTRCOUNT_EN
        checkOutput("count_reset", instrCount, 32'd0);
`endif
        reset = 1'b0;
        #1;
        checkOutput("reset_after", obsCtl, vIdle);

        // addcc with immediate ack
        stepClock(); checkOutput("add_fetch",  obsCtl, vFetchAck);
        stepClock(); checkOutput("add_decode", obsCtl, vIdle);
        stepClock(); checkOutput("add_alu",    obsCtl, vAluAdd);
        stepClock(); checkOutput("add_pcinc",  obsCtl, vPcInc);
        stepClock(); checkOutput("add_fetch2", obsCtl, vFetchAck);

        // Load with ack delayed three cycles
        applyStimulus(1'b0, 1'b1, 8'b11_000000, 1'b0);
        stepClock(); checkOutput("ld_decode", obsCtl, vIdle);
        memAck = 1'b0;
        stepClock(); checkOutput("ld_lda", obsCtl, vAddr);
        for (int i = 0; i < 3; i++) begin
            stepClock();
            checkOutput($sformatf("ld_wait%0d", i), obsCtl, vLdwWait);
        end
        memAck = 1'b1;
        #1;
        checkOutput("ld_ack", obsCtl, vLdwAck);
        stepClock(); checkOutput("ld_pcinc", obsCtl, vPcInc);
        stepClock(); checkOutput("ld_fetch", obsCtl, vFetchAck);

        // Store with ack delayed two cycles
        applyStimulus(1'b0, 1'b1, 8'b11_000100, 1'b0);
        stepClock();
        memAck = 1'b0;
        stepClock(); checkOutput("st_sta", obsCtl, vAddr);
        stepClock(); checkOutput("st_wait0", obsCtl, vStw);
        stepClock(); checkOutput("st_wait1", obsCtl, vStw);
        memAck = 1'b1;
        #1;
        checkOutput("st_ack", obsCtl, vStw);
        stepClock(); checkOutput("st_pcinc", obsCtl, vPcInc);
        stepClock(); checkOutput("st_fetch", obsCtl, vFetchAck);

        // Branch taken
        applyStimulus(1'b0, 1'b1, 8'b00_010_000, 1'b1);
        stepClock();
        stepClock(); checkOutput("br_t_disp",  obsCtl, vBr);
        stepClock(); checkOutput("br_t_add",   obsCtl, vBr2);
        stepClock(); checkOutput("br_t_fetch", obsCtl, vFetchAck);

        // Branch not taken
        applyStimulus(1'b0, 1'b1, 8'b00_010_000, 1'b0);
        stepClock();
        stepClock(); checkOutput("br_n_disp",  obsCtl, vBr);
        stepClock(); checkOutput("br_n_pcinc", obsCtl, vPcInc);
        stepClock(); checkOutput("br_n_fetch", obsCtl, vFetchAck);

        // SETHI
        applyStimulus(1'b0, 1'b1, 8'b00_100_000, 1'b0);
        stepClock();
        stepClock(); checkOutput("sethi", obsCtl, vSethi);
        stepClock(); checkOutput("sethi_pcinc", obsCtl, vPcInc);
        stepClock();

        // CALL
        applyStimulus(1'b0, 1'b1, 8'b01_000000, 1'b0);
        stepClock();
        stepClock(); checkOutput("call1", obsCtl, vCall1);
        stepClock(); checkOutput("call2", obsCtl, vCall2);
        stepClock(); checkOutput("call3", obsCtl, vBr2);
        stepClock(); checkOutput("call_fetch", obsCtl, vFetchAck);

        // JMPL
        applyStimulus(1'b0, 1'b1, 8'b10_111000, 1'b0);
        stepClock();
        stepClock(); checkOutput("jmp1", obsCtl, vAddr);
        stepClock(); checkOutput("jmp2", obsCtl, vJmp2);
        stepClock(); checkOutput("jmp3", obsCtl, vJmp3);
        stepClock(); checkOutput("jmp_fetch", obsCtl, vFetchAck);

        // Illegal opcode halts; ack is ignored there
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
        stepClock();
        for (int i = 0; i < 20; i++) begin
            stepClock();
            checkOutput($sformatf("halt%0d", i), obsCtl, vHalt);
        end

        // Reset clears halt, then reset interrupts a FETCH wait
        applyStimulus(1'b1, 1'b0, 8'b10_010000, 1'b0);
        stepClock(); checkOutput("halt_reset", obsCtl, vIdle);
        reset = 1'b0;
        stepClock(); checkOutput("fetch_wait0", obsCtl, vFetchWait);
        stepClock(); checkOutput("fetch_wait1", obsCtl, vFetchWait);
        reset = 1'b1;
        stepClock(); checkOutput("fetch_wait_reset", obsCtl, vIdle);

        // Five back-to-back addcc instructions
        reset  = 1'b0;
        memAck = 1'b1;
        stepClock();
        for (int i = 0; i < 5; i++) begin
            stepClock();
            stepClock();
            stepClock(); checkOutput($sformatf("loop_pcinc%0d", i), obsCtl, vPcInc);
            stepClock();
        end
`ifdef ARC_CU_INSTRCOUNT_EN
        checkOutput("count_five", instrCount, 32'd5);
        reset = 1'b1;
        stepClock();
        checkOutput("count_cleared", instrCount, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
